tick_period_meter: RTL
======================

Name: tick_period_meter

Overview:
Receive-side companion to the team's periodic tick generator. Measures the clock-cycle interval between successive rising edges of an incoming tick/strobe and presents each measurement on a valid/ready output port. Detects missing ticks (timeout) and reports measurements dropped because the consumer stalled. Used for tick self-check, rate monitoring and walker-speed calibration.

Parameters:
WIDTH, 16, width of o_period and of the internal elapsed counter
TIMEOUT, 50000, elapsed-cycle limit without an edge; legal range 2..2^WIDTH-1 (elaboration-time check)

Ports:
i_clk  input  1  clock
i_rst  input  1  synchronous reset, active-high
i_tick  input  1  tick/strobe, synchronous to i_clk; any high width accepted
o_period  output  WIDTH  measured interval in clock cycles
o_valid  output  1  o_period holds an unconsumed measurement
i_ready  input  1  consumer accepts o_period when o_valid && i_ready
o_timeout  output  1  one-cycle pulse: no edge within TIMEOUT cycles
o_overrun  output  1  one-cycle pulse: measurement dropped, output register occupied

Behaviour:
- Reset (i_rst high at a clock edge): state IDLE, elapsed counter 0, tick history register 0, o_period 0, o_valid 0, o_timeout 0, o_overrun 0. i_rst overrides all other activity, including a pending o_valid and any edge in the same cycle.
- Edge detect: edge = i_tick && !prev; prev <= i_tick every cycle. Level held high = one edge. i_tick high on the first cycle after reset counts as an edge.
- Elapsed value e = ctr + 1; WIDTH-bit arithmetic, never wraps, because ctr is bounded by TIMEOUT-1.
- IDLE: ctr held 0. On edge -> MEASURE, ctr <= 0. No measurement reported.
- MEASURE, per cycle, in priority order:
  - edge: measurement = e; ctr <= 0; stay MEASURE. Ticks every N cycles give period N.
  - no edge, e == TIMEOUT: o_timeout pulses on the next cycle; -> IDLE; ctr <= 0.
  - otherwise ctr <= e.
- An edge on the cycle where e == TIMEOUT reports period TIMEOUT; no timeout.
- Latency: o_valid/o_period update on the clock edge that ends the edge cycle, so they are visible the cycle after the tick edge. o_timeout and o_overrun share this 1-cycle latency.
- Output register, when a measurement is produced:
  - o_valid == 0: load o_period, o_valid <= 1.
  - o_valid == 1 && i_ready: old value consumed; load new value; o_valid stays 1.
  - o_valid == 1 && !i_ready: new value discarded, o_period unchanged, o_overrun pulses.
- With no new measurement, o_valid && i_ready clears o_valid; o_period retains its last value.
- o_period is stable while o_valid && !i_ready.
- All outputs are registered; no combinational path from i_ready or i_tick to any output.

Test Plan:
- Reset, then i_tick 1-cycle pulses every 4 cycles, i_ready=1 -> no output for the first edge; o_valid=1 with o_period=4 one cycle after each later edge; o_timeout=0 throughout.
- Edges at intervals 10 then 7, i_ready=0 -> o_period=10, o_valid held; o_overrun pulses once, one cycle after the second edge; o_period stays 10. i_ready=1 for one cycle -> o_valid drops.
- o_valid=1 (period 9), i_ready=1 on the same cycle as a new edge at interval 6 -> o_valid stays 1, o_period=6, no o_overrun.
- TIMEOUT=20, one edge then silence -> o_timeout pulses exactly once, 20 cycles after the edge cycle plus one; no o_valid. Next edge -> nothing reported; edge 5 cycles later -> o_period=5.
- TIMEOUT=20, edges exactly 20 cycles apart -> o_period=20, o_timeout never asserts. Edges 21 apart -> timeout each interval, no o_valid.
- i_tick held high for 30 cycles, then pulses -> single edge counted. i_rst asserted mid-MEASURE with o_valid=1 -> all outputs 0 the next cycle. i_tick high at reset release -> first post-reset cycle treated as an edge.

Source files
------------

// File: rtl/tick_period_meter.sv
// Measures the clock-cycle interval between rising edges of i_tick and presents each
// measurement on a valid/ready port, flagging missing ticks and stalled-consumer drops.
module tick_period_meter #(
    parameter int WIDTH   = 16,
    parameter int TIMEOUT = 50000
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_tick,
    output logic [WIDTH-1:0] o_period,
    output logic             o_valid,
    input  logic             i_ready,
    output logic             o_timeout,
    output logic             o_overrun
);

    generate
        if (TIMEOUT < 2 || longint'(TIMEOUT) > (longint'(1) << WIDTH) - 1) begin : g_bad_timeout
            $error("tick_period_meter: TIMEOUT must lie in 2..2^WIDTH-1");
        end
    endgenerate

    localparam logic [WIDTH-1:0] TIMEOUT_W = WIDTH'(TIMEOUT);

    typedef enum logic {
        ST_IDLE,
        ST_MEASURE
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] ctr_q;
    logic [WIDTH-1:0] elapsed_d;
    logic             tick_prev_q;
    logic             tick_edge;
    logic             meas_avail;
    logic [WIDTH-1:0] period_q;
    logic             valid_q;
    logic             timeout_q;
    logic             overrun_q;

    assign tick_edge  = i_tick & ~tick_prev_q;
    // ctr_q never exceeds TIMEOUT-1, so the increment cannot wrap
    assign elapsed_d  = ctr_q + WIDTH'(1);
    assign meas_avail = (state_q == ST_MEASURE) && tick_edge;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= ST_IDLE;
            ctr_q       <= '0;
            tick_prev_q <= 1'b0;
            period_q    <= '0;
            valid_q     <= 1'b0;
            timeout_q   <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            tick_prev_q <= i_tick;
            timeout_q   <= 1'b0;
            overrun_q   <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    ctr_q <= '0;
                    if (tick_edge) begin
                        state_q <= ST_MEASURE;
                    end
                end
                ST_MEASURE: begin
                    if (tick_edge) begin
                        ctr_q <= '0;
                    end else if (elapsed_d == TIMEOUT_W) begin
                        timeout_q <= 1'b1;
                        state_q   <= ST_IDLE;
                        ctr_q     <= '0;
                    end else begin
                        ctr_q <= elapsed_d;
                    end
                end
            endcase

            // A held, unconsumed result wins over a fresh one; the fresh one is dropped
            if (meas_avail) begin
                if (!valid_q || i_ready) begin
                    period_q <= elapsed_d;
                    valid_q  <= 1'b1;
                end else begin
                    overrun_q <= 1'b1;
                end
            end else if (valid_q && i_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign o_period  = period_q;
    assign o_valid   = valid_q;
    assign o_timeout = timeout_q;
    assign o_overrun = overrun_q;

endmodule
